top: RTL and testbench

TOP -- requirements
Module: top

---
 rtl/top.sv | 111 +++++++++++
 tb/tb_top.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/top.sv
// top: sequential signed radix-4 (modified) Booth multiplier, one recoding step per clock.
// Defining TOP_DONE_FLAG_EN adds a registered done_out flag that is high once the counter saturates.
module top #(
   parameter int INPUT_WIDTH  = 6,
   parameter int OUTPUT_WIDTH = 12,
   parameter int COUNTER_SIZE = 3
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic [INPUT_WIDTH-1:0]  multiplicand_in,
   input  logic [INPUT_WIDTH-1:0]  multiplier_in,
`ifdef TOP_DONE_FLAG_EN
   output logic                    done_out,
`endif
   output logic [OUTPUT_WIDTH-1:0] product_top,
   output logic [COUNTER_SIZE-1:0] counter_top
);

   localparam logic [COUNTER_SIZE-1:0] LAST_STEP = COUNTER_SIZE'(INPUT_WIDTH / 2);
   localparam logic [COUNTER_SIZE-1:0] DONE_CNT  = COUNTER_SIZE'(INPUT_WIDTH / 2 + 1);
   localparam logic [COUNTER_SIZE-1:0] CNT_ONE   = {{(COUNTER_SIZE-1){1'b0}}, 1'b1};

   logic [INPUT_WIDTH-1:0]  mcand_r, mcand_next_s;
   logic [INPUT_WIDTH-1:0]  mult_r, mult_next_s;
   logic [OUTPUT_WIDTH-1:0] product_r, product_next_s;
   logic [COUNTER_SIZE-1:0] counter_r, counter_next_s;
   logic [OUTPUT_WIDTH-1:0] mcand_ext_s;
   logic [INPUT_WIDTH:0]    mult_ext_s;
   logic [INPUT_WIDTH:0]    mult_shift_s;
   logic [COUNTER_SIZE:0]   shift_amt_s;
   logic [2:0]              triplet_s;
   logic [OUTPUT_WIDTH-1:0] pp_s;

   // Booth digit selection; the multiple is already sign-extended to the full product width.
   function automatic logic [OUTPUT_WIDTH-1:0] booth_pp(
      input logic [2:0]              bits,
      input logic [OUTPUT_WIDTH-1:0] m
   );
      logic [OUTPUT_WIDTH-1:0] m2;
      m2 = {m[OUTPUT_WIDTH-2:0], 1'b0};
      case (bits)
         3'b000:  booth_pp = {OUTPUT_WIDTH{1'b0}};
         3'b001:  booth_pp = m;
         3'b010:  booth_pp = m;
         3'b011:  booth_pp = m2;
         3'b100:  booth_pp = -m2;
         3'b101:  booth_pp = -m;
         3'b110:  booth_pp = -m;
         3'b111:  booth_pp = {OUTPUT_WIDTH{1'b0}};
         default: booth_pp = {OUTPUT_WIDTH{1'b0}};
      endcase
   endfunction

   // Recoding window {m[2k+1], m[2k], m[2k-1]} with the implicit zero below the LSB.
   always_comb begin
      mcand_ext_s  = {{(OUTPUT_WIDTH-INPUT_WIDTH){mcand_r[INPUT_WIDTH-1]}}, mcand_r};
      mult_ext_s   = {mult_r, 1'b0};
      shift_amt_s  = {counter_r, 1'b0};
      mult_shift_s = mult_ext_s >> shift_amt_s;
      triplet_s    = mult_shift_s[2:0];
      pp_s         = booth_pp(triplet_s, mcand_ext_s) << shift_amt_s;
   end

   // Next-state: reset captures operands; otherwise accumulate one step, count, then saturate.
   always_comb begin
      mcand_next_s   = mcand_r;
      mult_next_s    = mult_r;
      product_next_s = product_r;
      counter_next_s = counter_r;
      if (rst_in) begin
         mcand_next_s   = multiplicand_in;
         mult_next_s    = multiplier_in;
         product_next_s = {OUTPUT_WIDTH{1'b0}};
         counter_next_s = {COUNTER_SIZE{1'b0}};
      end else begin
         if (counter_r < LAST_STEP) begin
            product_next_s = product_r + pp_s;
         end else begin
            product_next_s = product_r;
         end
         if (counter_r < DONE_CNT) begin
            counter_next_s = counter_r + CNT_ONE;
         end else begin
            counter_next_s = counter_r;
         end
      end
   end

   // State registers; reset is folded into the next-state logic so it stays synchronous.
   always_ff @(posedge clk_in) begin
      mcand_r   <= mcand_next_s;
      mult_r    <= mult_next_s;
      product_r <= product_next_s;
      counter_r <= counter_next_s;
   end

   assign product_top = product_r;
   assign counter_top = counter_r;

`ifdef TOP_DONE_FLAG_EN
   logic done_r;

   // Done flag tracks the saturated counter value on the same edge.
   always_ff @(posedge clk_in) begin
      done_r <= (counter_next_s == DONE_CNT);
   end

   assign done_out = done_r;
`endif

endmodule

// File: tb/tb_top.sv
// tb_top: randomized bench for the Booth multiplier top, checked every cycle against a
// behavioural model (partial product = a * signed value of the multiplier's low 2k bits).
module tb_top;
   localparam int IW = 6;
   localparam int OW = 12;
   localparam int CW = 3;

   logic          clk_in = 1'b0;
   logic          rst_in = 1'b1;
   logic [IW-1:0] multiplicand_in = '0;
   logic [IW-1:0] multiplier_in = '0;
   logic [OW-1:0] product_top;
   logic [CW-1:0] counter_top;
`ifdef TOP_DONE_FLAG_EN
   logic          done_out;
`endif

   int total = 0;
   int bad = 0;
   int m_a = 0;
   int m_b = 0;
   int m_k = 0;
   bit m_valid = 1'b0;

   top #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .COUNTER_SIZE(CW)) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .multiplicand_in(multiplicand_in),
      .multiplier_in(multiplier_in),
`ifdef TOP_DONE_FLAG_EN
      .done_out(done_out),
`endif
      .product_top(product_top),
      .counter_top(counter_top)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // After k steps the accumulator holds a times the signed value of b's low 2k bits.
   function automatic logic [31:0] exp_prod(input int a, input int b, input int k);
      int kk;
      int low;
      int p;
      kk = (k > IW / 2) ? IW / 2 : k;
      if (kk == 0) return 32'd0;
      low = b & ((1 << (2 * kk)) - 1);
      if (low >= (1 << (2 * kk - 1))) low = low - (1 << (2 * kk));
      p = a * low;
      return 32'(p & ((1 << OW) - 1));
   endfunction

   always @(posedge clk_in) begin
      if (rst_in) begin
         m_a     <= int'($signed(multiplicand_in));
         m_b     <= int'($signed(multiplier_in));
         m_k     <= 0;
         m_valid <= 1'b1;
      end else if (m_k < IW / 2 + 1) begin
         m_k <= m_k + 1;
      end
   end

   always @(negedge clk_in) begin
      if (m_valid) begin
         chk("model_cnt", 32'(counter_top), 32'(m_k));
         chk("model_prod", 32'(product_top), exp_prod(m_a, m_b, m_k));
`ifdef TOP_DONE_FLAG_EN
         chk("model_done", 32'(done_out), 32'(m_k == IW / 2 + 1));
`endif
      end
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic scramble();
      multiplicand_in = IW'($urandom);
      multiplier_in   = IW'($urandom);
   endtask

   task automatic start(input int a, input int b);
      rst_in          = 1'b1;
      multiplicand_in = IW'(a);
      multiplier_in   = IW'(b);
      tick();
      chk("reset_cnt", 32'(counter_top), 32'd0);
      chk("reset_prod", 32'(product_top), 32'd0);
`ifdef TOP_DONE_FLAG_EN
      chk("reset_done", 32'(done_out), 32'd0);
`endif
      rst_in = 1'b0;
      scramble();
   endtask

   task automatic run_lit(input string name, input int a, input int b, input logic [31:0] expv);
      start(a, b);
      for (int i = 1; i <= 6; i++) begin
         tick();
         scramble();
         chk({name, "_cnt"}, 32'(counter_top), 32'((i > 4) ? 4 : i));
         if (i >= 3) chk({name, "_prod"}, 32'(product_top), expv);
`ifdef TOP_DONE_FLAG_EN
         chk({name, "_done"}, 32'(done_out), 32'(i >= 4));
`endif
      end
   endtask

   initial begin
      tick();
      run_lit("p31x24", 31, 24, 32'h2E8);
      run_lit("n20xn31", -20, -31, 32'h26C);
      run_lit("n23xn17", -23, -17, 32'h187);
      run_lit("p31xn32", 31, -32, 32'hC20);
      run_lit("n32xn32", -32, -32, 32'h400);
      run_lit("z0xn1", 0, -1, 32'h000);

      // Abort mid-operation and restart with new operands.
      start(31, 24);
      tick();
      chk("abort_cnt1", 32'(counter_top), 32'd1);
      start(-20, -31);
      for (int i = 1; i <= 3; i++) tick();
      chk("abort_cnt3", 32'(counter_top), 32'd3);
      chk("abort_prod", 32'(product_top), 32'h26C);

      for (int n = 0; n < 200; n++) begin
         rst_in = 1'b1;
         multiplicand_in = ($urandom_range(0, 3) == 0) ? 6'b100000 : IW'($urandom);
         multiplier_in   = ($urandom_range(0, 3) == 0) ? 6'b100000 : IW'($urandom);
         repeat ($urandom_range(1, 2)) tick();
         rst_in = 1'b0;
         for (int c = 0; c < int'($urandom_range(1, 7)); c++) begin
            scramble();
            tick();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
